// File: rtl/codec_i2c_pkg.sv
// codec_i2c_pkg: shared CODEC control-port types and constants (target and sequencer)
package codec_i2c_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK, S_REG, S_DATA, S_EXTRA, S_TX, S_MACK, S_IGNORE
  } i2c_tgt_state_t;
  localparam logic [6:0] CODEC_I2C_ADDR = 7'h1A;
  localparam int CODEC_NUM_REGS = 19;
  // Read bytes: low 8 bits first, then the 9th bit, then zero padding
  function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic [8:0] r);
    return idx == 2'd0 ? r[7:0] : idx == 2'd1 ? {7'b0, r[8]} : 8'h00;
  endfunction
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-flop SCL/SDA synchronizers with SCL edge and START/STOP pulses
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  logic [2:0] r_scl, r_sda;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl <= '1;
      r_sda <= '1;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  end
  assign o_sda      = r_sda[1];
  assign o_scl_rise = r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] & r_scl[2];
  assign o_start    = r_scl[1] & r_scl[2] & ~r_sda[1] & r_sda[2];
  assign o_stop     = r_scl[1] & r_scl[2] & r_sda[1] & ~r_sda[2];
endmodule

// File: rtl/i2c_codec_target.sv
// i2c_codec_target: SSM2603-style I2C control-port responder with a 9-bit register file
module i2c_codec_target
  import codec_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = CODEC_I2C_ADDR,
  parameter int         NUM_REGS = CODEC_NUM_REGS,
  parameter int         REG_AW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              reg_wr_valid,
  output logic [REG_AW-1:0] reg_wr_addr,
  output logic [8:0]        reg_wr_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [8:0]        dbg_data
);
  i2c_tgt_state_t    r_state, w_next, r_after;
  logic              w_sda, w_rise, w_fall, w_start, w_stop, w_r, w_f;
  logic              w_p_ok, w_last, w_rx, w_commit;
  logic [2:0]        r_cnt;
  logic [7:0]        r_sh, w_byte, w_tx;
  logic [6:0]        w_p;
  logic [1:0]        r_idx, w_idx;
  logic              r_b8, r_sda_oe, r_wr_valid;
  logic [REG_AW-1:0] r_ptr, r_wr_addr;
  logic [8:0]        r_wr_data;
  logic [8:0]        r_regs [NUM_REGS];

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .i_scl     (scl_i),
    .i_sda     (sda_i),
    .o_sda     (w_sda),
    .o_scl_rise(w_rise),
    .o_scl_fall(w_fall),
    .o_start   (w_start),
    .o_stop    (w_stop)
  );

  // START/STOP take precedence over any coincident SCL edge
  assign w_r      = w_rise & ~(w_start | w_stop);
  assign w_f      = w_fall & ~(w_start | w_stop);
  assign w_byte   = {r_sh[6:0], w_sda};
  assign w_p      = w_byte[7:1];
  assign w_p_ok   = int'(w_p) < NUM_REGS;
  assign w_last   = r_cnt == 3'd7;
  assign w_rx     = r_state inside {S_ADDR, S_REG, S_DATA};
  assign w_idx    = r_state == S_MACK ? r_idx + {1'b0, r_idx != 2'd2} : 2'd0;
  assign w_tx     = tx_byte(w_idx, r_regs[r_ptr]);
  assign w_commit = w_f && r_state == S_ACK && !r_sda_oe && r_after == S_EXTRA;

  always_comb begin
    w_next = r_state;
    if (w_start) w_next = S_ADDR;
    else if (w_stop) w_next = S_IDLE;
    else if (w_r && w_last && r_state == S_ADDR) w_next = w_p == DEV_ADDR ? S_ACK : S_IGNORE;
    else if (w_r && w_last && r_state == S_REG) w_next = w_p_ok ? S_ACK : S_IGNORE;
    else if (w_r && w_last && r_state == S_DATA) w_next = S_ACK;
    else if (w_r && r_state == S_MACK && w_sda) w_next = S_IGNORE;
    else if (w_f && r_state == S_ACK && r_sda_oe) w_next = r_after;
    else if (w_f && r_state == S_TX && r_cnt == 3'd0) w_next = S_MACK;
    else if (w_f && r_state == S_MACK) w_next = S_TX;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // In ACK, r_sda_oe doubles as the phase flag: low = first fall, high = end of ACK clock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_sh       <= '0;
      r_idx      <= '0;
      r_b8       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_ptr      <= '0;
      r_after    <= S_IDLE;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_valid <= w_commit;
      if (w_start || w_stop) begin
        r_sda_oe <= 1'b0;
        r_cnt    <= '0;
      end else if (w_r) begin
        if (w_rx || r_state == S_TX) r_cnt <= r_cnt + 3'd1;
        if (w_rx) r_sh <= w_byte;
        if (w_last && r_state == S_ADDR) r_after <= w_byte[0] ? S_TX : S_REG;
        if (w_last && r_state == S_REG && w_p_ok) begin
          r_ptr   <= w_p[REG_AW-1:0];
          r_b8    <= w_byte[0];
          r_after <= S_DATA;
        end
        if (w_last && r_state == S_DATA) r_after <= S_EXTRA;
      end else if (w_f) begin
        if (r_state == S_ACK && !r_sda_oe) r_sda_oe <= 1'b1;
        else if ((r_state == S_ACK && r_after == S_TX) || r_state == S_MACK) begin
          r_sh     <= w_tx;
          r_idx    <= w_idx;
          r_sda_oe <= ~w_tx[7];
        end else if (r_state == S_TX && r_cnt != 3'd0) begin
          r_sh     <= {r_sh[6:0], 1'b0};
          r_sda_oe <= ~r_sh[6];
        end else r_sda_oe <= 1'b0;
      end
      if (w_commit) begin
        r_regs[r_ptr] <= {r_b8, r_sh};
        r_wr_addr     <= r_ptr;
        r_wr_data     <= {r_b8, r_sh};
      end
    end
  end

  assign sda_oe       = r_sda_oe;
  assign reg_wr_valid = r_wr_valid;
  assign reg_wr_addr  = r_wr_addr;
  assign reg_wr_data  = r_wr_data;
  assign dbg_data     = int'(dbg_addr) < NUM_REGS ? r_regs[dbg_addr] : 9'd0;
endmodule

// File: tb/tb_i2c_codec_target.sv
// tb_i2c_codec_target: bit-banged I2C master with scoreboarded ACK/read-byte/write-pulse checks
module tb_i2c_codec_target;
  localparam int Q = 8;
  logic        clk = 1'b0, reset = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
  logic        sda_oe, reg_wr_valid, w_bus;
  logic [4:0]  reg_wr_addr, dbg_addr = '0;
  logic [8:0]  reg_wr_data, dbg_data;
  int          tests = 0, fails = 0, viol = 0, nbus = 0, nwr = 0;
  logic [15:0] exp_bus[$], obs_bus[$], mon_o, mon_e;
  logic [13:0] exp_wr[$], mon_w;
  logic        watch = 1'b0, oe_seen = 1'b0, prev_oe = 1'b0;

  always #5 clk = ~clk;
  assign w_bus = m_sda & ~sda_oe;

  i2c_codec_target dut (
    .clk         (clk),
    .reset       (reset),
    .scl_i       (m_scl),
    .sda_i       (w_bus),
    .sda_oe      (sda_oe),
    .reg_wr_valid(reg_wr_valid),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dbg_chk(input string name, input logic [4:0] a, input logic [8:0] e);
    dbg_addr = a;
    #1;
    check(name, 16'(dbg_data), 16'(e));
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    s = w_bus;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic start_c();
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(2 * Q);
    m_sda = 1'b0;
    tick(2 * Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(2 * Q);
    m_sda = 1'b1;
    tick(2 * Q);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    obs_bus.push_back({8'h41, 7'b0, ~s});
  endtask

  task automatic rd_byte(input logic mack);
    logic s;
    logic [7:0] v;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      v[i] = s;
    end
    clk_bit(~mack, s);
    obs_bus.push_back({8'h52, v});
  endtask

  task automatic exp_ack(input logic a);
    exp_bus.push_back({8'h41, 7'b0, a});
  endtask

  task automatic exp_rd(input logic [7:0] v);
    exp_bus.push_back({8'h52, v});
  endtask

  // Scoreboard monitor: pairs observed bus results and write pulses with queued expectations
  always @(negedge clk) begin
    while (obs_bus.size() > 0) begin
      mon_o = obs_bus.pop_front();
      nbus++;
      if (exp_bus.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bus[%0d]: got %h with nothing expected", nbus, mon_o);
      end else begin
        mon_e = exp_bus.pop_front();
        check($sformatf("bus[%0d]", nbus), mon_o, mon_e);
      end
    end
    if (reg_wr_valid) begin
      nwr++;
      if (exp_wr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr[%0d]: unexpected write addr %0d data %h", nwr, reg_wr_addr, reg_wr_data);
      end else begin
        mon_w = exp_wr.pop_front();
        check($sformatf("wr[%0d]", nwr), 16'({reg_wr_addr, reg_wr_data}), 16'(mon_w));
      end
    end
    if (!reset && sda_oe !== prev_oe && m_scl) viol++;
    if (watch && sda_oe === 1'b1) oe_seen = 1'b1;
    prev_oe = sda_oe;
  end

  initial begin
    logic s;
    tick(4);
    check("rst_oe_valid", 16'({sda_oe, reg_wr_valid}), 16'd0);
    check("rst_wr_addr", 16'(reg_wr_addr), 16'd0);
    check("rst_wr_data", 16'(reg_wr_data), 16'd0);
    dbg_chk("rst_dbg0", 5'd0, 9'd0);
    reset = 1'b0;
    tick(4);
    // Basic write: reg 7 <= 0x155
    repeat (3) exp_ack(1'b1);
    exp_wr.push_back({5'd7, 9'h155});
    start_c(); wr_byte(8'h34); wr_byte(8'h0F); wr_byte(8'h55); stop_c();
    tick(4);
    dbg_chk("dbg7_write", 5'd7, 9'h155);
    // reg 3 <= 0x1A5, then read it back through a repeated START
    repeat (3) exp_ack(1'b1);
    exp_wr.push_back({5'd3, 9'h1A5});
    start_c(); wr_byte(8'h34); wr_byte(8'h07); wr_byte(8'hA5); stop_c();
    repeat (3) exp_ack(1'b1);
    exp_rd(8'hA5);
    exp_rd(8'h01);
    start_c(); wr_byte(8'h34); wr_byte(8'h06); start_c(); wr_byte(8'h35); rd_byte(1'b1); rd_byte(1'b0); stop_c();
    // Read with retained pointer, past the two real bytes
    exp_ack(1'b1);
    exp_rd(8'hA5); exp_rd(8'h01); exp_rd(8'h00);
    start_c(); wr_byte(8'h35); rd_byte(1'b1); rd_byte(1'b1); rd_byte(1'b0); stop_c();
    dbg_chk("dbg3_after_read", 5'd3, 9'h1A5);
    // Address mismatch: fully silent
    repeat (3) exp_ack(1'b0);
    watch = 1'b1;
    start_c(); wr_byte(8'h36); wr_byte(8'h0F); wr_byte(8'h55); stop_c();
    watch = 1'b0;
    check("mismatch_oe_silent", 16'(oe_seen), 16'd0);
    dbg_chk("dbg7_mismatch", 5'd7, 9'h155);
    // Out-of-range pointers 31 and 19 NACK; 18 is the last valid register
    exp_ack(1'b1); exp_ack(1'b0); exp_ack(1'b0);
    start_c(); wr_byte(8'h34); wr_byte(8'h3E); wr_byte(8'h55); stop_c();
    exp_ack(1'b1); exp_ack(1'b0); exp_ack(1'b0);
    start_c(); wr_byte(8'h34); wr_byte(8'h26); wr_byte(8'h12); stop_c();
    repeat (3) exp_ack(1'b1);
    exp_wr.push_back({5'd18, 9'h012});
    start_c(); wr_byte(8'h34); wr_byte(8'h24); wr_byte(8'h12); stop_c();
    tick(2);
    dbg_chk("dbg18", 5'd18, 9'h012);
    dbg_chk("dbg19_oor", 5'd19, 9'h000);
    dbg_chk("dbg31_oor", 5'd31, 9'h000);
    // Abort a DATA byte after 4 bits with a repeated START
    exp_ack(1'b1); exp_ack(1'b1);
    start_c(); wr_byte(8'h34); wr_byte(8'h0E);
    for (int i = 0; i < 4; i++) clk_bit(i[0], s);
    start_c();
    dbg_chk("dbg7_abort", 5'd7, 9'h155);
    repeat (3) exp_ack(1'b1);
    exp_wr.push_back({5'd7, 9'h077});
    wr_byte(8'h34); wr_byte(8'h0E); wr_byte(8'h77); stop_c();
    tick(2);
    dbg_chk("dbg7_after_abort", 5'd7, 9'h077);
    // Reset during the address ACK
    start_c();
    for (int i = 7; i >= 0; i--) clk_bit(i == 5 || i == 4 || i == 2, s);
    m_sda = 1'b1;
    tick(Q);
    check("ack_oe_driven", 16'(sda_oe), 16'd1);
    m_scl = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("reset_oe_release", 16'(sda_oe), 16'd0);
    check("reset_wr_valid", 16'(reg_wr_valid), 16'd0);
    dbg_chk("reset_dbg7", 5'd7, 9'd0);
    dbg_chk("reset_dbg3", 5'd3, 9'd0);
    tick(2);
    reset = 1'b0;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
    stop_c();
    // After reset the pointer is 0 and reg 0 reads back as zero
    exp_ack(1'b1);
    exp_rd(8'h00);
    start_c(); wr_byte(8'h35); rd_byte(1'b0); stop_c();
    repeat (3) exp_ack(1'b1);
    exp_wr.push_back({5'd5, 9'h1FF});
    start_c(); wr_byte(8'h34); wr_byte(8'h0B); wr_byte(8'hFF); stop_c();
    exp_ack(1'b1);
    exp_rd(8'hFF); exp_rd(8'h01);
    start_c(); wr_byte(8'h35); rd_byte(1'b1); rd_byte(1'b0); stop_c();
    tick(20);
    check("bus_exp_left", 16'(exp_bus.size()), 16'd0);
    check("wr_exp_left", 16'(exp_wr.size()), 16'd0);
    check("oe_change_scl_high", 16'(viol), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
